// File: rtl/mf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mf_pkg
//  Description : Shared constants and state encoding for the Mersenne-factor
//                modular exponentiation controller (2^p mod q).
//  Revision    : 1.0 - initial release
// ============================================================================
package mf_pkg;

    // Default operand widths: candidate factor q and Mersenne exponent p
    localparam int MF_QBITS = 32;
    localparam int MF_EBITS = 32;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SKIP     = 3'd1,
        SQ_START = 3'd2,
        SQ_GAP   = 3'd3,
        SQ_WAIT  = 3'd4,
        DBL      = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage : mf_pkg
`default_nettype wire

// File: rtl/mod_exp_ctrl_divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Sequential restoring divider producing numerator mod
//                denominator. One quotient bit per cycle, BITWIDTH cycles per
//                division. finished idles high, drops the edge after a start
//                is taken and rises again on the final iteration edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider #(
    parameter int BITWIDTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [BITWIDTH-1:0] numerator_i,
    input  logic [BITWIDTH-1:0] denominator_i,
    output logic [BITWIDTH-1:0] remainder_o,
    output logic                finished_o
);

    localparam int CNTW = $clog2(BITWIDTH + 1);

    logic [BITWIDTH-1:0] rem_q, rem_d;
    logic [BITWIDTH-1:0] quo_q, quo_d;
    logic [BITWIDTH-1:0] den_q, den_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                fin_q, fin_d;

    logic [BITWIDTH:0]   shift_w;
    logic [BITWIDTH:0]   sub_w;
    logic                ge_w;

    // Partial remainder shifted left with the next numerator bit brought in
    assign shift_w = {rem_q, quo_q[BITWIDTH-1]};
    assign sub_w   = shift_w - {1'b0, den_q};
    assign ge_w    = (shift_w >= {1'b0, den_q});

    // Next-state: load on start when idle, otherwise one restoring step per cycle
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        den_d = den_q;
        cnt_d = cnt_q;
        run_d = run_q;
        fin_d = fin_q;
        if (!run_q && start_i) begin
            rem_d = '0;
            quo_d = numerator_i;
            den_d = denominator_i;
            cnt_d = CNTW'(BITWIDTH);
            run_d = 1'b1;
            fin_d = 1'b0;
        end else if (run_q) begin
            // Remainder always stays below the denominator, so it fits BITWIDTH bits
            rem_d = ge_w ? BITWIDTH'(sub_w) : BITWIDTH'(shift_w);
            quo_d = {quo_q[BITWIDTH-2:0], ge_w};
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                run_d = 1'b0;
                fin_d = 1'b1;
            end
        end
    end

    // Division state registers; active-low reset aborts any division in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            quo_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            fin_q <= 1'b1;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            den_q <= den_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            fin_q <= fin_d;
        end
    end

    assign remainder_o = rem_q;
    assign finished_o  = fin_q;

endmodule : divider
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_ctrl
//  Description : Computes 2^p mod q by left-to-right binary exponentiation to
//                test whether q divides the Mersenne number 2^p-1. Squaring
//                reduction uses the shared sequential divider; doubling is a
//                single conditional subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl
    import mf_pkg::*;
#(
    parameter int QBITS = MF_QBITS,
    parameter int EBITS = MF_EBITS
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [EBITS-1:0] exponent,
    input  logic [QBITS-1:0] candidate,
    output logic             busy,
    output logic             done,
    output logic [QBITS-1:0] result,
    output logic             is_factor,
    output logic             error
);

    localparam int IDXW = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam int DW   = 2 * QBITS;

    state_t           state_q, state_d;
    logic [EBITS-1:0] p_q, p_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [QBITS-1:0] r_q, r_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             err_pend_q, err_pend_d;
    logic             done_q, done_d;
    logic [QBITS-1:0] result_q, result_d;
    logic             is_factor_q, is_factor_d;
    logic             error_q, error_d;

    logic             div_start;
    logic             div_rst_n;
    logic             div_finished;
    logic [DW-1:0]    div_num;
    logic [DW-1:0]    div_den;
    logic [DW-1:0]    div_rem;

    logic [DW-1:0]    sq_w;
    logic [QBITS:0]   dbl_t_w;
    logic [QBITS-1:0] dbl_r_w;
    logic             cur_bit_w;

    // Full-width square of the running residue feeds the divider
    assign sq_w    = DW'(r_q) * DW'(r_q);
    assign div_num = sq_w;
    assign div_den = DW'(q_q);

    // Doubling with r<q gives t<2q, so one conditional subtract restores r<q
    assign dbl_t_w = {r_q, 1'b0};
    assign dbl_r_w = (dbl_t_w >= {1'b0, q_q}) ? QBITS'(dbl_t_w - {1'b0, q_q})
                                               : QBITS'(dbl_t_w);

    assign cur_bit_w = p_q[idx_q];
    assign div_rst_n = ~sys_rst;

    divider #(
        .BITWIDTH (DW)
    ) u_divider (
        .clk_i         (sys_clk),
        .rst_ni        (div_rst_n),
        .start_i       (div_start),
        .numerator_i   (div_num),
        .denominator_i (div_den),
        .remainder_o   (div_rem),
        .finished_o    (div_finished)
    );

    // Next-state and datapath updates for the exponentiation sequence
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        r_d         = r_q;
        idx_d       = idx_q;
        err_pend_d  = err_pend_q;
        done_d      = 1'b0;
        result_d    = result_q;
        is_factor_d = is_factor_q;
        error_d     = error_q;
        div_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d   = exponent;
                    q_d   = candidate;
                    r_d   = QBITS'(1);
                    idx_d = IDXW'(EBITS - 1);
                    // Operands below 2 are rejected without any arithmetic
                    if (((candidate >> 1) == '0) || ((exponent >> 1) == '0)) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        err_pend_d = 1'b0;
                        state_d    = SKIP;
                    end
                end
            end
            SKIP: begin
                // Walk down from the top bit until the leading one of p
                if (cur_bit_w) begin
                    state_d = SQ_START;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            SQ_START: begin
                div_start = 1'b1;
                state_d   = SQ_GAP;
            end
            SQ_GAP: begin
                // finished from the previous division is stale here
                state_d = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (div_finished) begin
                    r_d     = QBITS'(div_rem);
                    state_d = DBL;
                end
            end
            DBL: begin
                if (cur_bit_w) begin
                    r_d = dbl_r_w;
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                    state_d = SQ_START;
                end
            end
            DONE: begin
                done_d      = 1'b1;
                result_d    = err_pend_q ? '0 : r_q;
                is_factor_d = ~err_pend_q && (r_q == QBITS'(1));
                error_d     = err_pend_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any operation and clears all outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            err_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            is_factor_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            err_pend_q  <= err_pend_d;
            done_q      <= done_d;
            result_q    <= result_d;
            is_factor_q <= is_factor_d;
            error_q     <= error_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign is_factor = is_factor_q;
    assign error     = error_q;

endmodule : mod_exp_ctrl
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_exp_ctrl
//  Description : Self-checking bench for mod_exp_ctrl with directed vectors
//                and randomized operands against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_ctrl;

    localparam int QB     = 32;
    localparam int EB     = 32;
    localparam int BUDGET = 4000;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic [EB-1:0] exponent;
    logic [QB-1:0] candidate;
    logic          busy;
    logic          done;
    logic [QB-1:0] result;
    logic          is_factor;
    logic          error;

    int checks = 0;
    int errors = 0;

    mod_exp_ctrl #(
        .QBITS (QB),
        .EBITS (EB)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .exponent  (exponent),
        .candidate (candidate),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .is_factor (is_factor),
        .error     (error)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: right-to-left square-and-multiply in 64-bit arithmetic
    function automatic longint unsigned ref_powmod(longint unsigned p, longint unsigned q);
        longint unsigned r = 1 % q;
        longint unsigned b = 2 % q;
        longint unsigned e = p;
        while (e != 0) begin
            if (e[0]) r = (r * b) % q;
            b = (b * b) % q;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic int bitlen(longint unsigned v);
        int n = 0;
        while (v != 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    // Cycles from the accepting edge to the edge that raises done
    function automatic int exp_lat(longint unsigned p, longint unsigned q);
        int l;
        if (q < 2 || p < 2) return 1;
        l = bitlen(p);
        return (EB - l + 1) + l * (2 * QB + 3) + 1;
    endfunction

    // Issue one operation and wait (bounded) for done; operand inputs are
    // scrambled right after acceptance to show they were latched
    task automatic run_op(input logic [EB-1:0] p, input logic [QB-1:0] q,
                          output int lat, output bit tmo, output bit busy_seen);
        @(negedge sys_clk);
        exponent  = p;
        candidate = q;
        start     = 1'b1;
        @(posedge sys_clk);
        #1;
        start     = 1'b0;
        exponent  = $urandom;
        candidate = $urandom;
        busy_seen = busy;
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        start     = 1'b0;
        exponent  = '0;
        candidate = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (is_factor !== 1'b0) begin errors++; $display("FAIL reset_is_factor got %b want 0", is_factor); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_known_vectors();
        int lat; bit tmo; bit bs;
        run_op(32'd11, 32'd23, lat, tmo, bs);
        checks++; if (tmo) begin errors++; $display("FAIL kv23_timeout got none want done"); end
        checks++; if (result !== 32'd1 || is_factor !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL kv23_out got r=%0d f=%b e=%b want r=1 f=1 e=0", result, is_factor, error); end
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL kv23_busy got %b want 1", bs); end
        run_op(32'd11, 32'd13, lat, tmo, bs);
        checks++; if (result !== 32'd7 || is_factor !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL kv13_out got r=%0d f=%b e=%b want r=7 f=0 e=0", result, is_factor, error); end
        checks++; if (lat != 298) begin errors++; $display("FAIL kv13_latency got %0d want 298", lat); end
        @(posedge sys_clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL kv13_pulse got done=%b busy=%b want 0 0", done, busy); end
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL kv13_hold got %0d want 7", result); end
    endtask

    task automatic test_back_to_back();
        int lat; bit tmo; bit bs;
        run_op(32'd29, 32'd233, lat, tmo, bs);
        checks++; if (result !== 32'd1 || is_factor !== 1'b1) begin
            errors++; $display("FAIL b2b_first got r=%0d f=%b want r=1 f=1", result, is_factor); end
        run_op(32'd7, 32'd127, lat, tmo, bs);
        checks++; if (result !== 32'd1 || is_factor !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL b2b_second got r=%0d f=%b e=%b want r=1 f=1 e=0", result, is_factor, error); end
        checks++; if (lat != exp_lat(7, 127)) begin
            errors++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_lat(7, 127)); end
    endtask

    task automatic test_errors();
        logic [EB-1:0] ps [4] = '{32'd11, 32'd1, 32'd0, 32'd11};
        logic [QB-1:0] qs [4] = '{32'd1, 32'd23, 32'd23, 32'd0};
        int lat; bit tmo; bit bs;
        for (int k = 0; k < 4; k++) begin
            run_op(32'd11, 32'd13, lat, tmo, bs);
            run_op(ps[k], qs[k], lat, tmo, bs);
            checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency got %0d want 1", k, lat); end
            checks++; if (error !== 1'b1 || result !== '0 || is_factor !== 1'b0) begin
                errors++; $display("FAIL err%0d_out got r=%0d f=%b e=%b want r=0 f=0 e=1", k, result, is_factor, error); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0; bit seen = 1'b0;
        @(negedge sys_clk);
        exponent = 32'd11; candidate = 32'd23; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge sys_clk); #1;
            lat++;
            if (done) begin seen = 1'b1; break; end
            if (lat == 50) begin start = 1'b1; exponent = 32'd13; candidate = 32'd7; end
            if (lat == 52) start = 1'b0;
        end
        checks++; if (!seen) begin errors++; $display("FAIL ign_timeout got none want done"); end
        checks++; if (result !== 32'd1 || is_factor !== 1'b1) begin
            errors++; $display("FAIL ign_out got r=%0d f=%b want r=1 f=1", result, is_factor); end
        checks++; if (lat != 298) begin errors++; $display("FAIL ign_latency got %0d want 298", lat); end
    endtask

    task automatic test_reset_midrun();
        int lat; bit tmo; bit bs; int dones = 0;
        run_op(32'd11, 32'd13, lat, tmo, bs);
        @(negedge sys_clk);
        exponent = 32'd29; candidate = 32'd233; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        // 28 SKIP cycles, then the first squaring is deep in its divider wait
        repeat (68) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || is_factor !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got b=%b d=%b r=%0d f=%b e=%b want all 0", busy, done, result, is_factor, error); end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk); #1;
            if (done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_nodone got %0d want 0", dones); end
        run_op(32'd11, 32'd23, lat, tmo, bs);
        checks++; if (tmo || result !== 32'd1 || is_factor !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after got r=%0d f=%b want r=1 f=1", result, is_factor); end
    endtask

    task automatic test_random();
        int lat; bit tmo; bit bs;
        logic [EB-1:0] p;
        logic [QB-1:0] q;
        longint unsigned er;
        bit inv;
        for (int k = 0; k < 12; k++) begin
            p = 32'($urandom) >> $urandom_range(0, 31);
            q = 32'($urandom) >> $urandom_range(0, 30);
            if (k == 0) q = 32'hFFFF_FFFB;
            if (k == 1) p = 32'hFFFF_FFFF;
            inv = (q < 2) || (p < 2);
            er  = inv ? 0 : ref_powmod(longint'(p), longint'(q));
            run_op(p, q, lat, tmo, bs);
            checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout got none want done", k); end
            checks++; if (result !== QB'(er) || is_factor !== (!inv && er == 1) || error !== inv) begin
                errors++; $display("FAIL rnd%0d_out p=%0d q=%0d got r=%0d f=%b e=%b want r=%0d f=%b e=%b",
                                   k, p, q, result, is_factor, error, er, (!inv && er == 1), inv); end
            checks++; if (lat != exp_lat(longint'(p), longint'(q))) begin
                errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, exp_lat(longint'(p), longint'(q))); end
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_errors();
        test_ignore_start();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mod_exp_ctrl
`default_nettype wire

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter QBITS, default 32, giving the candidate factor width q.
REQ-002 SHALL have parameter EBITS, default 32, giving the Mersenne exponent width p.
REQ-003 SHALL have port sys_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a request sampled only in IDLE.
REQ-006 SHALL have port exponent, input, EBITS bits, p, latched on accepted start.
REQ-007 SHALL have port candidate, input, QBITS bits, q, latched on accepted start.
REQ-008 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port result, output, QBITS bits, 2^p mod q, valid from done until the next accepted start.
REQ-011 SHALL have port is_factor, output, 1 bit, result==1 (q divides 2^p-1), valid with result.
REQ-012 SHALL have port error, output, 1 bit, invalid operands, valid with result.

Function
REQ-013 SHALL use states IDLE, SKIP, SQ_START, SQ_GAP, SQ_WAIT, DBL, DONE.
REQ-014 SHALL, in IDLE with start=1, latch p and q, set r=1, and go to SKIP, or to DONE with error=1, result=0, is_factor=0 if q<2 or p<2.
REQ-015 SHALL, in SKIP, discard leading zero bits of p at one bit per cycle, then go to SQ_START on the cycle the MSB is found, spending EBITS-L+1 cycles in SKIP, where L is the bit length of p.
REQ-016 SHALL process the L bits MSB-first with left-to-right binary exponentiation: r = r*r mod q, then, if the bit is 1, r = 2r mod q.
REQ-017 SHALL, in SQ_START, assert the modulo unit's start for exactly one cycle with numerator r*r (2*QBITS bits) and denominator q zero-extended.
REQ-018 SHALL spend exactly one cycle in SQ_GAP and SHALL ignore the unit's finished there, because finished is still high in the start cycle.
REQ-019 SHALL stay in SQ_WAIT until finished=1, then load r from the low QBITS bits of the remainder and go to DBL.
REQ-020 SHALL, in DBL, compute the doubling combinationally as t=r<<1 (QBITS+1 bits), r=t-q if t>=q else t, only when the current bit is 1.
REQ-021 SHALL, in DBL, go to SQ_START if bits remain, else to DONE.
REQ-022 SHALL cost exactly 2*QBITS+3 cycles per processed exponent bit.
REQ-023 SHALL, in DONE, drive done=1 for one cycle, update result, is_factor and error, and return to IDLE.
REQ-024 SHALL ignore start while busy=1; operands latched at acceptance are not affected by later input changes.
REQ-025 SHALL accept a start in the cycle immediately after done (back-to-back operation).
REQ-026 SHALL hold r<q as an invariant after every SQ_WAIT and DBL step.

Reset
REQ-027 SHALL, on sys_rst=1 at any time including mid-operation, go to IDLE and clear busy, done, result, is_factor and error to 0.
REQ-028 SHALL drive the modulo unit's active-low reset from ~sys_rst, so that reset also aborts an in-flight division.
REQ-029 SHALL not produce a done pulse for an operation aborted by reset.

Structure
REQ-030 SHALL take its state encodings and default QBITS/EBITS constants from the shared package mf_pkg.
REQ-031 SHALL instantiate exactly one team modulo unit, divider, with BITWIDTH=2*QBITS; the multiply and doubling logic stays local.

Verification
REQ-032 SHALL cover: p=11, q=23 -> result=1, is_factor=1, error=0.
REQ-033 SHALL cover: p=11, q=13 -> result=7, is_factor=0, and done exactly (32-4+1)+4*67+1 cycles after the start edge at QBITS=EBITS=32.
REQ-034 SHALL cover: p=29, q=233 -> result=1, is_factor=1; then p=7, q=127 started on the cycle after done -> result=1.
REQ-035 SHALL cover: q=1 or p=1 -> done one cycle after start, error=1, result=0, is_factor=0.
REQ-036 SHALL cover: start pulsed again mid-run with different operands -> ignored, and the first result is unchanged.
REQ-037 SHALL cover: sys_rst asserted during SQ_WAIT -> outputs 0 immediately, no done pulse, and the next start with p=11, q=23 yields result=1.
